// File: rtl/pipe_chain_pkg.sv
// Shared types and helpers for the elastic pipeline chain (depth limit, flush mask type, popcount).
package pipe_chain_pkg;

  localparam int MAX_DEPTH = 8;

  typedef logic [MAX_DEPTH-1:0] flush_mask_t;

  // Counts up to MAX_DEPTH stage valids plus one skid valid.
  function automatic logic [3:0] popcount(input logic [MAX_DEPTH:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i <= MAX_DEPTH; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_chain_stage.sv
// One elastic stage: valid+data register; loads when downstream is ready, flush wins over load.
// Single-cycle register; backpressure is handled by the caller via i_load.
module pipe_chain_stage
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_flush,
  input  logic             i_src_valid,
  input  logic [WIDTH-1:0] i_src_data,
  output logic             o_valid,
  output logic             o_valid_nxt,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Data is loaded even when the source is invalid or squashed; only valid is cleared.
  always_comb begin
    o_valid_nxt = (i_load ? i_src_valid : r_valid) & ~i_flush;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= o_valid_nxt;
      if (i_load) r_data <= i_src_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipe_chain.sv
// Chain of DEPTH elastic stages, DEPTH-cycle latency, bubbles collapse under backpressure.
// ELASTIC_PIPE_CHAIN_SKID_EN adds a 1-entry skid before stage 0 so in_ready is a flop.
module elastic_pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [WIDTH-1:0]             i_in_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [WIDTH-1:0]             o_out_data,
  input  logic [DEPTH-1:0]             i_flush_mask,
  output logic [DEPTH-1:0]             o_stage_valid,
  output logic [$clog2(DEPTH+2)-1:0]   o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH+2);

  logic [DEPTH:0]              w_ready;
  logic [DEPTH-1:0]            w_valid;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] w_data;
  logic [DEPTH-1:0]            w_src_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_src_data;
  logic                        w_skid_nxt;
  logic [MAX_DEPTH:0]          w_pop_vec;
  logic [3:0]                  w_cnt;
  logic [OCC_W-1:0]            r_occ;

  // Ready ripples back from the output; it never sees flush_mask.
  assign w_ready[DEPTH] = i_out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign w_ready[k] = ~w_valid[k] | w_ready[k+1];

    if (k > 0) begin : g_link
      assign w_src_valid[k] = w_valid[k-1];
      assign w_src_data[k]  = w_data[k-1];
    end

    pipe_chain_stage #(.WIDTH(WIDTH)) u_stage (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_load      (w_ready[k]),
      .i_flush     (i_flush_mask[k]),
      .i_src_valid (w_src_valid[k]),
      .i_src_data  (w_src_data[k]),
      .o_valid     (w_valid[k]),
      .o_valid_nxt (w_valid_nxt[k]),
      .o_data      (w_data[k])
    );
  end

`ifdef ELASTIC_PIPE_CHAIN_SKID_EN
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_in_ready;
  logic             w_park;

  // Park only when the input is taken but stage 0 cannot load; the skid drains before new input.
  assign w_park         = i_in_valid & r_in_ready & ~w_ready[0];
  assign w_skid_nxt     = (r_skid_valid ? ~w_ready[0] : w_park) & ~i_flush_mask[0];
  assign w_src_valid[0] = r_skid_valid | (i_in_valid & r_in_ready);
  assign w_src_data[0]  = r_skid_valid ? r_skid_data : i_in_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_in_ready   <= 1'b0;
    end else begin
      r_skid_valid <= w_skid_nxt;
      r_in_ready   <= ~w_skid_nxt;
      if (w_park) r_skid_data <= i_in_data;
    end
  end

  assign o_in_ready = r_in_ready;
`else
  assign w_skid_nxt     = 1'b0;
  assign w_src_valid[0] = i_in_valid;
  assign w_src_data[0]  = i_in_data;
  assign o_in_ready     = w_ready[0] & ~i_rst;
`endif

  always_comb begin
    w_pop_vec              = '0;
    w_pop_vec[DEPTH-1:0]   = w_valid_nxt;
    w_pop_vec[MAX_DEPTH]   = w_skid_nxt;
    w_cnt                  = popcount(w_pop_vec);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_occ <= '0;
    else       r_occ <= w_cnt[OCC_W-1:0];
  end

  assign o_out_valid   = w_valid[DEPTH-1];
  assign o_out_data    = w_data[DEPTH-1];
  assign o_stage_valid = w_valid;
  assign o_occupancy   = r_occ;

endmodule

// File: tb/tb_elastic_pipe_chain.sv
// Scoreboard bench for elastic_pipe_chain: expected outputs queued at input accept, popped at output handshake.
module tb_elastic_pipe_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic [DEPTH-1:0]           flush_mask;
  logic [DEPTH-1:0]           stage_valid;
  logic [$clog2(DEPTH+2)-1:0] occupancy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_out_cyc = -1;
  int last_out_cyc = -1;
  int start_cyc;
  logic [WIDTH-1:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elastic_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_data    (in_data),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .i_flush_mask (flush_mask),
    .o_stage_valid(stage_valid),
    .o_occupancy  (occupancy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        check_eq("out_data", out_data, exp);
        if (exp == 32'h1 && first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    flush_mask = '0;
  endtask

  // Present one word; keep=1 means it must reach the output.
  task automatic send(input logic [WIDTH-1:0] v, input bit keep, input logic [DEPTH-1:0] fm);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    in_data    = v;
    flush_mask = fm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (fm != '0 && i == 0) check_eq("flush_in_ready", {31'b0, in_ready}, 32'd1);
      if (in_ready) begin
        if (keep) sb.push_back(v);
        done = 1'b1;
      end
      step();
    end
    if (!done) check_eq("send_timeout", {31'b0, done}, 32'd1);
    flush_mask = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) step();
    check_eq("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'h77;
    out_ready  = 1'b1;
    flush_mask = '0;
    step();
    step();
    check_eq("rst_stage_valid", 32'(stage_valid), 32'd0);
    check_eq("rst_occupancy",   32'(occupancy),   32'd0);
    check_eq("rst_out_valid",   {31'b0, out_valid}, 32'd0);
    check_eq("rst_in_ready",    {31'b0, in_ready},  32'd0);

    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("post_rst_occ",      32'(occupancy),    32'd0);

    // Back-to-back stream with no backpressure.
    start_cyc = cyc;
    for (int v = 1; v <= 8; v++) send(32'(v), 1'b1, '0);
    check_eq("stream_accept_cycles", 32'(cyc - start_cyc), 32'd8);
    idle();
    drain();
    check_eq("stream_first_latency", 32'(first_out_cyc - start_cyc), 32'd3);
    check_eq("stream_last_cycle",    32'(last_out_cyc - start_cyc),  32'd10);

    // Full chain held under backpressure.
    out_ready = 1'b0;
    send(32'hA, 1'b1, '0);
    send(32'hB, 1'b1, '0);
    send(32'hC, 1'b1, '0);
    idle();
    repeat (4) begin
`ifdef ELASTIC_PIPE_CHAIN_SKID_EN
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd1);
`else
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
`endif
      check_eq("bp_occupancy",   32'(occupancy),   32'd3);
      check_eq("bp_out_data",    out_data,         32'hA);
      check_eq("bp_stage_valid", 32'(stage_valid), 32'd7);
      step();
    end
    out_ready = 1'b1;
    drain();

    // Bubble collapse: build stage valids 1,0,1 then fill the hole.
    out_ready = 1'b0;
    send(32'h31, 1'b1, '0);
    idle();
    step();
    send(32'h32, 1'b1, '0);
    check_eq("bubble_pattern",  32'(stage_valid), 32'b101);
    check_eq("bubble_in_ready", {31'b0, in_ready}, 32'd1);
    send(32'h33, 1'b1, '0);
    idle();
    check_eq("bubble_collapsed", 32'(stage_valid), 32'b111);
    check_eq("bubble_occupancy", 32'(occupancy),   32'd3);
    out_ready = 1'b1;
    drain();

    // Squash stages 0 and 1 mid-stream; 0x12 and 0x13 must never appear.
    send(32'h10, 1'b1, '0);
    send(32'h11, 1'b1, '0);
    send(32'h12, 1'b0, '0);
    send(32'h13, 1'b0, 3'b011);
    check_eq("flush_stage_valid", 32'(stage_valid), 32'b100);
    check_eq("flush_occupancy",   32'(occupancy),   32'd1);
    send(32'h14, 1'b1, '0);
    idle();
    drain();

`ifdef ELASTIC_PIPE_CHAIN_SKID_EN
    // Full chain plus one word parked in the skid.
    out_ready = 1'b0;
    send(32'h21, 1'b1, '0);
    send(32'h22, 1'b1, '0);
    send(32'h23, 1'b1, '0);
    send(32'h55, 1'b1, '0);
    idle();
    check_eq("skid_in_ready",  {31'b0, in_ready}, 32'd0);
    check_eq("skid_occupancy", 32'(occupancy),    32'd4);
    out_ready = 1'b1;
    drain();
`endif

    repeat (5) step();
    check_eq("final_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("final_out_valid", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
